// File: rtl/uart_pkg.sv
// UART shared types and constants.
// Common to the RX and TX paths.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART.
// The master drives it, the consumer uses the slave view.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a
// previous-sample flop used for start-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_s,
  output logic start_edge
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // All-zero reset: a line held low across reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rx_s       = s2_q;
  assign start_edge = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid
// pulse per good byte, framing-error pulse on a low stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_i,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  logic rx_s;
  logic start_edge;

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (rx_i),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST) state_d = STOP;
          else idx_d = idx_q + 1'b1;
        end
      end
      STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start edge be seen.
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: ideal 8N1 transmitter, a frame-level
// scoreboard of expected pulses, and a per-cycle compare.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int LAT = CPB / 2 + 9 * CPB + 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx_i  = 1'b1;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_i  (rx_i),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         good;
    time        t0;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] mdl_data = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         vc = 0;
  int         ec = 0;
  time        tv_prev = 0;
  time        tv_last = 0;
  bit         rst_now;
  longint     lat;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint v,
                         input longint lo, input longint hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, v, lo, hi);
    end
  endtask

  // Compare process: one pass per clock, just after the edge.
  always @(posedge clk) begin
    rst_now = !reset;
    #1;
    if (rst_now) begin
      q.delete();
      mdl_data = 8'h00;
      chk("rst_busy", u_if.busy, 0);
      chk("rst_valid", u_if.rx_valid, 0);
      chk("rst_err", u_if.frame_err, 0);
      chk("rst_data", u_if.rx_data, 0);
    end else begin
      chk("excl", u_if.rx_valid & u_if.frame_err, 0);
      if (u_if.rx_valid) begin
        vc++;
        tv_prev = tv_last;
        tv_last = $time;
      end
      if (u_if.frame_err) ec++;
      if (u_if.rx_valid || u_if.frame_err) begin
        if (q.size() == 0) begin
          chk("spurious", {u_if.rx_valid, u_if.frame_err}, 0);
        end else begin
          e = q.pop_front();
          lat = ($time - e.t0 + 4) / 10;
          chk("kind", {u_if.rx_valid, u_if.frame_err},
              e.good ? 32'd2 : 32'd1);
          chk_rng("latency", lat, LAT - 1, LAT + 1);
          if (e.good) mdl_data = e.data;
        end
      end else if (q.size() != 0) begin
        lat = ($time - q[0].t0 + 4) / 10;
        if (lat > LAT + 1) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing: no pulse for %0h after %0d clk",
                   q[0].data, lat);
          void'(q.pop_front());
        end
      end
      chk("rx_data", u_if.rx_data, mdl_data);
    end
  end

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send(input logic [7:0] d, input bit good,
                      input int stop_len);
    exp_t x;
    x.data = d;
    x.good = good;
    x.t0   = $time;
    q.push_back(x);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = good;
    repeat (stop_len) @(negedge clk);
  endtask

  task automatic settle();
    idle(8);
    chk("q_empty", q.size(), 0);
    chk("busy_idle", u_if.busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int v0, e0, nb;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(10);

    v0 = vc; e0 = ec;
    send(8'hA5, 1'b1, CPB);
    settle();
    chk("t1_data", u_if.rx_data, 8'hA5);
    chk("t1_nv", vc - v0, 1);
    chk("t1_ne", ec - e0, 0);

    v0 = vc; e0 = ec;
    send(8'h00, 1'b1, CPB);
    send(8'hFF, 1'b1, CPB);
    settle();
    chk("t2_data", u_if.rx_data, 8'hFF);
    chk("t2_nv", vc - v0, 2);
    chk("t2_ne", ec - e0, 0);
    chk("t2_gap", (tv_last - tv_prev) / 10, 160);

    v0 = vc; e0 = ec;
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (u_if.busy) nb++;
    end
    chk_rng("t3_busy_cycles", nb, 1, 9);
    chk("t3_busy_end", u_if.busy, 0);
    chk("t3_nv", vc - v0, 0);
    chk("t3_ne", ec - e0, 0);
    send(8'h3C, 1'b1, CPB);
    settle();
    chk("t3_data", u_if.rx_data, 8'h3C);

    v0 = vc; e0 = ec;
    send(8'h12, 1'b1, CPB);
    idle(4);
    send(8'h55, 1'b0, 2 * CPB);
    chk("t4_busy_break", u_if.busy, 1);
    idle(6);
    chk("t4_busy_after", u_if.busy, 0);
    settle();
    chk("t4_data", u_if.rx_data, 8'h12);
    chk("t4_nv", vc - v0, 1);
    chk("t4_ne", ec - e0, 1);

    // Reset lands in the middle of data bit 3.
    fork
      send(8'h81, 1'b1, CPB);
      begin
        repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    join
    v0 = vc; e0 = ec;
    chk("t5_busy", u_if.busy, 0);
    chk("t5_data_rst", u_if.rx_data, 0);
    idle(4);
    send(8'hC3, 1'b1, CPB);
    settle();
    chk("t5_data", u_if.rx_data, 8'hC3);
    chk("t5_nv", vc - v0, 1);
    chk("t5_ne", ec - e0, 0);

    rx_i = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    v0 = vc; e0 = ec;
    repeat (100) begin
      @(negedge clk);
      chk("t6_busy_low", u_if.busy, 0);
    end
    idle(2 * CPB);
    send(8'h7E, 1'b1, CPB);
    settle();
    chk("t6_data", u_if.rx_data, 8'h7E);
    chk("t6_nv", vc - v0, 1);
    chk("t6_ne", ec - e0, 0);

    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        send(d, 1'b1, CPB);
        if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 20));
      end else begin
        send(d, 1'b0, CPB + $urandom_range(0, CPB));
        idle(8 + $urandom_range(0, 8));
      end
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
